// File: rtl/proc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// proc_ctrl_pkg
//   Shared processor-control definitions: instruction opcode constants,
//   ALU op constants and the multiply/divide sequencer state type.
//   No ports (package).
// ---------------------------------------------------------------------------
package proc_ctrl_pkg;

    // Instruction opcodes
    localparam logic [4:0] OPC_RTYPE = 5'b00000;
    localparam logic [4:0] OPC_J     = 5'b00001;
    localparam logic [4:0] OPC_BNE   = 5'b00010;
    localparam logic [4:0] OPC_JAL   = 5'b00011;
    localparam logic [4:0] OPC_JR    = 5'b00100;
    localparam logic [4:0] OPC_ADDI  = 5'b00101;
    localparam logic [4:0] OPC_BLT   = 5'b00110;
    localparam logic [4:0] OPC_SW    = 5'b00111;
    localparam logic [4:0] OPC_LW    = 5'b01000;
    localparam logic [4:0] OPC_SETX  = 5'b10101;
    localparam logic [4:0] OPC_BEX   = 5'b10110;

    // R-type ALU op field
    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/multdiv_iter_unit.sv
// ---------------------------------------------------------------------------
// multdiv_iter_unit
//   Shared iterative datapath for unsigned magnitude multiply (shift-add) and
//   restoring divide. One step per cycle while step_mul_i / step_div_i is high.
//
//   Registers:
//     acc_q : 2*WIDTH accumulator (MUL product) / partial remainder (DIV)
//     sh_q  : 2*WIDTH multiplicand, shifted left every MUL step; holds the
//             divisor (low WIDTH bits) during DIV
//     sr_q  : WIDTH multiplier shift register (MUL, shifts right) /
//             dividend-in, quotient-out shift register (DIV, shifts left)
//
// Ports
//   clock_i, resetn_i  clock, asynchronous active-low reset
//   load_i             clear accumulator, load sh_q/sr_q from load_sh_i/load_sr_i
//   step_mul_i         perform one shift-add step
//   step_div_i         perform one restoring divide step
//   load_sh_i          multiplicand (MUL) or divisor (DIV) magnitude
//   load_sr_i          multiplier (MUL) or dividend (DIV) magnitude
//   acc_nxt_o          accumulator value after the current step
//   sr_nxt_o           shift register value after the current step
//   sr_nxt_zero_o      sr_nxt_o is all zero (no multiplier bits left)
// ---------------------------------------------------------------------------
module multdiv_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clock_i,
    input  logic                 resetn_i,
    input  logic                 load_i,
    input  logic                 step_mul_i,
    input  logic                 step_div_i,
    input  logic [WIDTH-1:0]     load_sh_i,
    input  logic [WIDTH-1:0]     load_sr_i,
    output logic [2*WIDTH-1:0]   acc_nxt_o,
    output logic [WIDTH-1:0]     sr_nxt_o,
    output logic                 sr_nxt_zero_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0]   sr_q, sr_d;

    // Restoring divide: bring the next dividend bit into the remainder and
    // try subtracting the divisor. The remainder stays below 2*divisor, so
    // the 2*WIDTH difference never wraps and its MSB is a true sign.
    logic [2*WIDTH-1:0] rem_sh;
    logic [2*WIDTH-1:0] trial;

    assign rem_sh = {acc_q[2*WIDTH-2:0], sr_q[WIDTH-1]};
    assign trial  = rem_sh - sh_q;

    always_comb begin
        acc_d = acc_q;
        sh_d  = sh_q;
        sr_d  = sr_q;
        if (load_i) begin
            acc_d = '0;
            sh_d  = {{WIDTH{1'b0}}, load_sh_i};
            sr_d  = load_sr_i;
        end else if (step_mul_i) begin
            // Multiplicand shifts left so the product is complete as soon as
            // the multiplier runs out of set bits.
            acc_d = acc_q + (sr_q[0] ? sh_q : '0);
            sh_d  = sh_q << 1;
            sr_d  = sr_q >> 1;
        end else if (step_div_i) begin
            if (!trial[2*WIDTH-1]) begin
                acc_d = trial;
                sr_d  = {sr_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = rem_sh;
                sr_d  = {sr_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            acc_q <= '0;
            sh_q  <= '0;
            sr_q  <= '0;
        end else begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            sr_q  <= sr_d;
        end
    end

    assign acc_nxt_o     = acc_d;
    assign sr_nxt_o      = sr_d;
    assign sr_nxt_zero_o = (sr_d == '0);

endmodule

// File: rtl/multdiv_sequencer.sv
// ---------------------------------------------------------------------------
// multdiv_sequencer
//   Execute-stage multicycle controller for signed MUL/DIV. Decodes the
//   issued instruction, stalls the pipeline while the shared iterative
//   datapath (multdiv_iter_unit) runs, and returns a signed WIDTH-bit result
//   with an exception flag (MUL overflow, DIV by zero, DIV INT_MIN/-1).
//
//   Optional feature: define MULTDIV_EARLY_TERM_EN to let MUL finish as soon
//   as the remaining multiplier bits are all zero (after at least one step).
//   Without it, MUL always takes WIDTH steps.
//
// Ports
//   clock         in   1      rising-edge clock
//   resetn        in   1      asynchronous active-low reset
//   issue         in   1      decode-stage instruction valid
//   opcode        in   5      instruction opcode
//   raw_aluop     in   5      instruction ALU op field
//   operandA      in   WIDTH  multiplicand / dividend
//   operandB      in   WIDTH  multiplier / divisor
//   stall         out  1      freeze PC and upstream pipeline registers
//   busy          out  1      FSM outside IDLE
//   result_valid  out  1      one-cycle pulse, result/exception valid
//   result        out  WIDTH  product low word / quotient
//   exception     out  1      overflow / divide-by-zero flag
//
// Handshake: an instruction is accepted only when issue is high in IDLE and
// decodes as MUL/DIV; stall rises combinationally in that same cycle and
// stays high until the cycle before result_valid, so the stalled instruction
// advances to writeback together with the result_valid pulse. issue while
// busy is ignored.
// ---------------------------------------------------------------------------
module multdiv_sequencer
    import proc_ctrl_pkg::*;
#(
    parameter int         WIDTH     = 32,
    parameter logic [4:0] MUL_ALUOP = ALU_MUL,
    parameter logic [4:0] DIV_ALUOP = ALU_DIV
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              issue,
    input  logic [4:0]        opcode,
    input  logic [4:0]        raw_aluop,
    input  logic [WIDTH-1:0]  operandA,
    input  logic [WIDTH-1:0]  operandB,
    output logic              stall,
    output logic              busy,
    output logic              result_valid,
    output logic [WIDTH-1:0]  result,
    output logic              exception
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;

    // Decode
    logic is_mul, is_div, start;
    assign is_mul = issue && (opcode == OPC_RTYPE) && (raw_aluop == MUL_ALUOP);
    assign is_div = issue && (opcode == OPC_RTYPE) && (raw_aluop == DIV_ALUOP);
    assign start  = is_mul || is_div;

    // Operand magnitudes. |INT_MIN| is 2^(WIDTH-1), which still fits as an
    // unsigned WIDTH-bit value.
    logic             sign_a, sign_b, b_zero;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign sign_a = operandA[WIDTH-1];
    assign sign_b = operandB[WIDTH-1];
    assign mag_a  = sign_a ? (~operandA + 1'b1) : operandA;
    assign mag_b  = sign_b ? (~operandB + 1'b1) : operandB;
    assign b_zero = (operandB == '0);

    // Datapath control
    logic               load, step_mul, step_div;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   sr_nxt;
    logic               sr_nxt_zero;

    multdiv_iter_unit #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clock_i       (clock),
        .resetn_i      (resetn),
        .load_i        (load),
        .step_mul_i    (step_mul),
        .step_div_i    (step_div),
        .load_sh_i     (is_mul ? mag_a : mag_b),
        .load_sr_i     (is_mul ? mag_b : mag_a),
        .acc_nxt_o     (acc_nxt),
        .sr_nxt_o      (sr_nxt),
        .sr_nxt_zero_o (sr_nxt_zero)
    );

    // Signed results formed from the post-step datapath values, so they can
    // be registered on the same edge that enters DONE.
    logic [2*WIDTH-1:0] prod_s;
    logic               mul_ovf;
    logic [WIDTH-1:0]   quot_s;
    logic               div_ovf;

    assign prod_s  = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
    // Product fits in WIDTH bits only if bits [2W-1:W-1] are all equal.
    assign mul_ovf = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
    assign quot_s  = neg_q ? (~sr_nxt + 1'b1) : sr_nxt;
    // A positive quotient with the MSB set can only be INT_MIN / -1; the raw
    // magnitude bits already equal INT_MIN.
    assign div_ovf = !neg_q && sr_nxt[WIDTH-1];

    // Last iteration of the current operation
    logic last_step, mul_done;
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MULTDIV_EARLY_TERM_EN
    assign mul_done  = last_step || sr_nxt_zero;
`else
    assign mul_done  = last_step;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        exc_d    = exc_q;
        load     = 1'b0;
        step_mul = 1'b0;
        step_div = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load  = 1'b1;
                    neg_d = sign_a ^ sign_b;
                    cnt_d = '0;
                    if (is_mul) begin
                        state_d = ST_MUL;
                    end else if (b_zero) begin
                        state_d  = ST_DONE;
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                step_mul = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (mul_done) begin
                    state_d  = ST_DONE;
                    result_d = prod_s[WIDTH-1:0];
                    exc_d    = mul_ovf;
                end
            end
            ST_DIV: begin
                step_div = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (last_step) begin
                    state_d  = ST_DONE;
                    result_d = quot_s;
                    exc_d    = div_ovf;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign stall        = ((state_q == ST_IDLE) && start) ||
                          (state_q == ST_MUL) || (state_q == ST_DIV);
    assign busy         = (state_q != ST_IDLE);
    assign result_valid = (state_q == ST_DONE);
    assign result       = result_q;
    assign exception    = exc_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
module tb_multdiv_sequencer;

  localparam int W = 32;

  logic         clock;
  logic         resetn;
  logic         issue;
  logic [4:0]   opcode;
  logic [4:0]   raw_aluop;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         stall;
  logic         busy;
  logic         result_valid;
  logic [W-1:0] result;
  logic         exception;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  multdiv_sequencer #(
    .WIDTH     (W),
    .MUL_ALUOP (5'b00110),
    .DIV_ALUOP (5'b00111)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .issue        (issue),
    .opcode       (opcode),
    .raw_aluop    (raw_aluop),
    .operandA     (operand_a),
    .operandB     (operand_b),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .exception    (exception)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  // ---------------- checker helper ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Arithmetic meaning of a MUL/DIV instruction plus its latency in cycles.
  function automatic void model_op(input bit is_div, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic [W-1:0] res,
                                   output logic exc, output int lat);
    longint p;
    int qa, qb;
    logic [W-1:0] mb;
    if (!is_div) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      res = p[W-1:0];
      exc = (p != longint'($signed(p[W-1:0])));
`ifdef MULTDIV_EARLY_TERM_EN
      mb  = b[W-1] ? (0 - b) : b;
      lat = 2;
      for (int i = 0; i < W; i++) if (mb[i]) lat = i + 2;
`else
      mb  = '0;
      lat = W + 1;
`endif
    end else begin
      mb  = '0;
      qa  = $signed(a);
      qb  = $signed(b);
      if (qb == 0) begin
        res = '0; exc = 1'b1; lat = 1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        res = 32'h8000_0000; exc = 1'b1; lat = W + 1;
      end else begin
        res = qa / qb; exc = 1'b0; lat = W + 1;
      end
    end
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [W-1:0] exp_q[$];
  bit           m_active = 0;
  int           m_start  = 0;
  int           m_lat    = 0;
  logic         m_exc    = 0;
  logic [W-1:0] h_res    = '0;
  logic         h_exc    = 0;

  always @(negedge clock) begin
    logic [W-1:0] r;
    logic         e;
    int           l;
    int           k;
    if (!resetn) begin
      chk("rst_stall", stall, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_exc", exception, 0);
      m_active = 0; h_res = '0; h_exc = 0; exp_q.delete();
    end else if (!m_active) begin
      if (issue && opcode == 5'b00000 && (raw_aluop == 5'b00110 || raw_aluop == 5'b00111)) begin
        model_op(raw_aluop == 5'b00111, operand_a, operand_b, r, e, l);
        exp_q.push_back(r);
        m_exc = e; m_lat = l; m_start = cyc; m_active = 1;
        chk("issue_stall", stall, 1);
        chk("issue_busy", busy, 0);
        chk("issue_valid", result_valid, 0);
      end else begin
        chk("idle_stall", stall, 0);
        chk("idle_busy", busy, 0);
        chk("idle_valid", result_valid, 0);
        chk("idle_result_hold", result, h_res);
        chk("idle_exc_hold", exception, h_exc);
      end
    end else begin
      k = cyc - m_start;
      chk("op_stall", stall, (k < m_lat) ? 1 : 0);
      chk("op_busy", busy, 1);
      chk("op_valid", result_valid, (k == m_lat) ? 1 : 0);
      if (k >= m_lat) begin
        h_res = exp_q.pop_front();
        h_exc = m_exc;
        chk("op_result", result, h_res);
        chk("op_exc", exception, h_exc);
        m_active = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one MUL/DIV, wait (bounded) for result_valid and pin the outcome to
  // hand-computed literals. inject fires a second MUL/DIV while busy.
  task automatic run_op(input string nm, input logic [4:0] alu, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] res, input logic exc,
                        input int lat_fixed, input int lat_et, input bit inject);
    int s;
    int lat;
    bit seen;
    int exp_lat;
`ifdef MULTDIV_EARLY_TERM_EN
    exp_lat = (alu == 5'b00110) ? lat_et : lat_fixed;
`else
    exp_lat = lat_fixed;
    if (lat_et < 0) exp_lat = lat_fixed;
`endif
    @(posedge clock); #1;
    issue = 1'b1; opcode = 5'b00000; raw_aluop = alu; operand_a = a; operand_b = b;
    s = cyc;
    @(posedge clock); #1;
    issue = 1'b0; operand_a = $urandom; operand_b = $urandom;
    seen = 0; lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (inject && (cyc - s) == 4) begin
        issue = 1'b1; raw_aluop = (alu == 5'b00110) ? 5'b00111 : 5'b00110;
        operand_a = 32'd12345; operand_b = 32'd0;
      end
      if (inject && (cyc - s) == 5) issue = 1'b0;
      if (result_valid) begin
        seen = 1; lat = cyc - s;
        break;
      end
    end
    if (!seen) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      chk({nm, "_lat"}, lat, exp_lat);
      chk({nm, "_res"}, result, res);
      chk({nm, "_exc"}, exception, exc);
    end
  endtask

  // Issue an instruction that is not MUL/DIV; it must not stall or start.
  task automatic run_other(input string nm, input logic [4:0] opc, input logic [4:0] alu);
    @(posedge clock); #1;
    issue = 1'b1; opcode = opc; raw_aluop = alu;
    operand_a = $urandom_range(1, 1000); operand_b = $urandom_range(1, 1000);
    @(negedge clock);
    chk({nm, "_stall"}, stall, 0);
    @(posedge clock); #1;
    issue = 1'b0;
    @(negedge clock);
    chk({nm, "_busy"}, busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    int pulses;
    resetn = 1'b0; issue = 1'b0; opcode = '0; raw_aluop = '0;
    operand_a = '0; operand_b = '0;
    repeat (3) @(posedge clock);
    #2 resetn = 1'b1;

    //      name          aluop     A              B              result         exc  fixed  et
    run_op("mul_7_n3",    5'b00110, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0,   33,    3,  0);
    run_op("div_100_7",   5'b00111, 32'd100,       32'd7,         32'd14,        0,   33,   33,  0);
    run_op("div_n100_7",  5'b00111, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 0,   33,   33,  0);
    run_op("div_100_n7",  5'b00111, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 0,   33,   33,  0);
    run_op("div_5_0",     5'b00111, 32'd5,         32'd0,         32'd0,         1,    1,    1,  0);
    run_op("mul_2p16sq",  5'b00110, 32'd65536,     32'd65536,     32'd0,         1,   33,   18,  0);
    run_op("mul_min_1",   5'b00110, 32'h8000_0000, 32'd1,         32'h8000_0000, 0,   33,    2,  0);
    run_op("div_min_n1",  5'b00111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,   33,   33,  0);
    run_op("mul_9_3",     5'b00110, 32'd9,         32'd3,         32'd27,        0,   33,    3,  0);
    run_op("mul_n6_n7",   5'b00110, 32'hFFFF_FFFA, 32'hFFFF_FFF9, 32'd42,        0,   33,    4,  0);
    run_op("mul_max_2",   5'b00110, 32'h7FFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1,   33,    3,  0);
    run_op("mul_5_0",     5'b00110, 32'd5,         32'd0,         32'd0,         0,   33,    2,  0);
    run_op("div_n7_2",    5'b00111, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0,   33,   33,  0);
    run_op("div_min_1",   5'b00111, 32'h8000_0000, 32'd1,         32'h8000_0000, 0,   33,   33,  0);
    run_op("div_inject",  5'b00111, 32'd1000,      32'hFFFF_FFF6, 32'hFFFF_FF9C, 0,   33,   33,  1);

    run_other("addi",     5'b00101, 5'b00110);
    run_other("rtype_sll", 5'b00000, 5'b00100);

    // Asynchronous abort of a running MUL at cycle 10
    @(posedge clock); #1;
    issue = 1'b1; opcode = 5'b00000; raw_aluop = 5'b00110;
    operand_a = 32'd123; operand_b = 32'hFFFF_FF00;
    s = cyc;
    @(posedge clock); #1;
    issue = 1'b0;
    while ((cyc - s) < 10) @(negedge clock);
    chk("abort_pre_busy", busy, 1);
    #2 resetn = 1'b0;
    #1;
    chk("abort_stall", stall, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", result_valid, 0);
    chk("abort_result", result, 0);
    repeat (2) @(negedge clock);
    #2 resetn = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (result_valid) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    run_other("add_after_rst", 5'b00000, 5'b00000);

    // One more op after the abort to confirm normal service resumes
    run_op("mul_n1_n1",   5'b00110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         0,   33,    2,  0);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    n_vec++;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
